game_channel_switch: RTL and testbench
======================================

# game_channel_switch

Parametrised, frame-synchronised game selector for the VGA pixel path. It chooses one of NUM_GAMES RGB sources by a debounced, synchronised select and registers the colour output. On a change it blanks the screen and holds the incoming game in reset for a fixed number of frames, so a game never starts mid-frame or from stale state. It sits between the per-game renderers and the VGA pins, in the pixel clock domain.

## Interface
Parameters:
- NUM_GAMES, 6, number of RGB sources; index 0 is the menu/intro screen.
- SEL_W, 3, select width; requires 2**SEL_W >= NUM_GAMES.
- COLOR_W, 4, bits per colour channel.
- SETTLE_FRAMES, 2, consecutive frame starts a new select must stay stable before switching (>=1).
- HOLD_FRAMES, 1, frame starts spent blanked, with the new game in reset (>=1).

Ports:
- clk_25MHz  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high; every flop clears immediately on assertion.
- sel  in  SEL_W  raw game select from switches; asynchronous to clk_25MHz.
- vsync  in  1  active-low vertical sync from the display counter.
- rgb_in  in  NUM_GAMES*3*COLOR_W  packed sources; game g occupies {red,green,blue} at bits [(g+1)*3*COLOR_W-1 : g*3*COLOR_W].
- red, green, blue  out  COLOR_W each  registered colour output.
- game_rst  out  NUM_GAMES  per-game hold-in-reset, 1 = held.
- active  out  SEL_W  index currently displayed.
- switching  out  1  high while the block is in SETTLE or BLANK.

## Operation
- sel passes through a 2-flop synchroniser, giving sel_s. A value >= NUM_GAMES maps to 0.
- frame_start is a one-cycle pulse on the falling edge of vsync, detected with a registered previous vsync.
- The FSM has three states: RUN, SETTLE and BLANK. Registered state is cand (SEL_W bits) and fcnt (frame counter, sized for max(SETTLE_FRAMES, HOLD_FRAMES)).
- RUN:
  - Output is rgb_in slice [active].
  - game_rst is all ones except bit [active], which is 0.
  - If sel_s != active: cand <= sel_s, fcnt <= 0, go to SETTLE.
- SETTLE:
  - Output and game_rst are as in RUN; the old game keeps running.
  - If sel_s == active: return to RUN (glitch absorbed), fcnt <= 0.
  - Otherwise, if sel_s != cand: cand <= sel_s, fcnt <= 0. This takes priority over counting in the same cycle.
  - Otherwise, on frame_start: fcnt++. When the incremented value reaches SETTLE_FRAMES: active <= cand, fcnt <= 0, go to BLANK.
- BLANK:
  - red, green and blue are 0, and game_rst is all ones.
  - sel is ignored.
  - On frame_start: fcnt++. When it reaches HOLD_FRAMES, go to RUN. Bit [active] then drops to 0 in that same registered update, so the game is released exactly at a frame start.
- A select change back while in BLANK is handled from RUN on the following cycles; it goes through SETTLE again.
- switching = (state != RUN).

## Timing
- Reset values: state RUN, active 0, cand 0, fcnt 0, red/green/blue 0, game_rst = all ones except bit 0 = 0, switching 0, synchroniser and vsync history flops 0.
- When reset deasserts, the sync flops are 0, so the first sel_s is 0 and matches active; no spurious switch occurs.
- RGB latency is one clk_25MHz cycle from rgb_in to red/green/blue. hcount/vcount alignment must account for that one cycle.
- Select latency:
  - sel to sel_s is 2 cycles.
  - The SETTLE entry is visible as switching = 1 on the 3rd edge after sel changes.
  - The switch lands on the SETTLE_FRAMES-th frame_start after entering SETTLE.
- frame_start is asserted in the cycle after the vsync falling edge.
- BLANK always lasts exactly HOLD_FRAMES frame starts, and the new game's release coincides with frame_start.
- Reset asserted mid-SETTLE or mid-BLANK aborts the operation immediately and returns to the reset values.
- If frame_start and a sel_s change occur in the same SETTLE cycle, the change wins: the counter restarts and there is no increment.

## Structure
- A shared package, game_pkg, holds:
  - the state enum (ST_RUN, ST_SETTLE, ST_BLANK);
  - MENU_IDX = 0;
  - the packed-RGB slice width function.
- Sub-module vsync_edge produces the synchroniser plus the frame_start pulse, and is reusable by the game blocks.
- The mux and FSM live in game_channel_switch.

## Test plan
- Reset, then sel=0 for 3 frames: active=0, switching=0, game_rst=6'b111110, output equals rgb_in game 0 delayed 1 cycle.
- sel 0 to 3, stable, defaults: switching rises 3 cycles later. At the 2nd frame_start, BLANK begins: rgb=0, game_rst=6'b111111, active=3. At the next frame_start: RUN, game_rst=6'b110111, output is game 3.
- sel pulses 0→2→0 within one frame: SETTLE entered and exited, active stays 0, screen never blanks.
- sel=7 with NUM_GAMES=6: treated as 0, no switch.
- sel changes 1→4 on the same cycle as frame_start during SETTLE: fcnt resets to 0, cand=4, and the switch needs 2 further frame starts.
- reset asserted mid-BLANK: outputs return to reset values immediately (asynchronously); after release, the block runs game 0.

Source files
------------

// File: rtl/game_channel_switch_pkg.sv
// Shared types and helpers for the game selector and the per-game blocks.
// Latency: none, declarations only.
// Backpressure: not applicable.
package game_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

  // Index 0 is always the menu/intro screen.
  localparam int MENU_IDX = 0;

  // Width of one game's packed {red,green,blue} slice.
  function automatic int rgb_slice_w(input int color_w);
    return 3 * color_w;
  endfunction

endpackage

// File: rtl/game_channel_switch_vsync_edge.sv
// Synchronises the raw game select and flags the first cycle of each frame.
// Latency: sel_s trails sel by 2 cycles; frame_start is high in the cycle after vsync falls.
// Backpressure: none, free-running; exactly one frame_start pulse per vsync falling edge.
module vsync_edge #(
  parameter int SEL_W = 3
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             vsync,
  output logic [SEL_W-1:0] sel_s,
  output logic             frame_start
);

  logic [SEL_W-1:0] sel_m;
  logic             vsync_q;

  // Two-flop synchroniser for the switch inputs plus one cycle of vsync history.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      sel_m   <= '0;
      sel_s   <= '0;
      vsync_q <= 1'b0;
    end else begin
      sel_m   <= sel;
      sel_s   <= sel_m;
      vsync_q <= vsync;
    end
  end

  // vsync is active-low, so a frame begins where it was high and is now low.
  assign frame_start = vsync_q & ~vsync;

endmodule

// File: rtl/game_channel_switch.sv
// Frame-synchronised selector of one game RGB source, blanking and holding the new game in reset on a change.
// Latency: 1 cycle rgb_in to red/green/blue; a select change lands SETTLE_FRAMES frame starts after SETTLE entry.
// Backpressure: none; sel is sampled continuously and ignored while blanked.
module game_channel_switch
  import game_pkg::*;
#(
  parameter int NUM_GAMES     = 6,
  parameter int SEL_W         = 3,
  parameter int COLOR_W       = 4,
  parameter int SETTLE_FRAMES = 2,
  parameter int HOLD_FRAMES   = 1
) (
  input  logic                           clk_25MHz,
  input  logic                           reset,
  input  logic [SEL_W-1:0]               sel,
  input  logic                           vsync,
  input  logic [NUM_GAMES*3*COLOR_W-1:0] rgb_in,
  output logic [COLOR_W-1:0]             red,
  output logic [COLOR_W-1:0]             green,
  output logic [COLOR_W-1:0]             blue,
  output logic [NUM_GAMES-1:0]           game_rst,
  output logic [SEL_W-1:0]               active,
  output logic                           switching
);

  localparam int RGB_W   = rgb_slice_w(COLOR_W);
  localparam int CNT_MAX = (SETTLE_FRAMES > HOLD_FRAMES) ? SETTLE_FRAMES : HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     SETTLE_END   = CNT_W'(SETTLE_FRAMES);
  localparam logic [CNT_W-1:0]     HOLD_END     = CNT_W'(HOLD_FRAMES);
  localparam logic [SEL_W:0]       GAMES_LIM    = (SEL_W+1)'(NUM_GAMES);
  localparam logic [SEL_W-1:0]     MENU         = SEL_W'(MENU_IDX);
  localparam logic [NUM_GAMES-1:0] GAME_RST_RST = ~(NUM_GAMES'(1) << MENU_IDX);

  logic [SEL_W-1:0] sel_s;
  logic [SEL_W-1:0] sel_v;
  logic             frame_start;

  state_t           state, nxt_state;
  logic [SEL_W-1:0] cand, nxt_cand, nxt_active;
  logic [CNT_W-1:0] fcnt, nxt_fcnt, cnt_inc;
  logic [RGB_W-1:0] nxt_rgb;

  vsync_edge #(.SEL_W(SEL_W)) u_vsync_edge (
    .clk_25MHz   (clk_25MHz),
    .reset       (reset),
    .sel         (sel),
    .vsync       (vsync),
    .sel_s       (sel_s),
    .frame_start (frame_start)
  );

  // Selects with no game behind them fall back to the menu.
  assign sel_v   = ({1'b0, sel_s} >= GAMES_LIM) ? MENU : sel_s;
  assign cnt_inc = fcnt + CNT_W'(1);
  assign nxt_rgb = rgb_in[int'(nxt_active)*RGB_W +: RGB_W];

  // Next-state decode; a select change in SETTLE outranks a frame_start in the same cycle.
  always_comb begin
    nxt_state  = state;
    nxt_active = active;
    nxt_cand   = cand;
    nxt_fcnt   = fcnt;
    case (state)
      ST_RUN: begin
        if (sel_v != active) begin
          nxt_cand  = sel_v;
          nxt_fcnt  = '0;
          nxt_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (sel_v == active) begin
          nxt_fcnt  = '0;
          nxt_state = ST_RUN;
        end else if (sel_v != cand) begin
          nxt_cand = sel_v;
          nxt_fcnt = '0;
        end else if (frame_start) begin
          if (cnt_inc == SETTLE_END) begin
            nxt_active = cand;
            nxt_fcnt   = '0;
            nxt_state  = ST_BLANK;
          end else begin
            nxt_fcnt = cnt_inc;
          end
        end
      end
      ST_BLANK: begin
        if (frame_start) begin
          if (cnt_inc == HOLD_END) begin
            nxt_fcnt  = '0;
            nxt_state = ST_RUN;
          end else begin
            nxt_fcnt = cnt_inc;
          end
        end
      end
      default: begin
        nxt_fcnt  = '0;
        nxt_state = ST_RUN;
      end
    endcase
  end

  // Register FSM state and drive outputs from the next state, so the release lands on the frame start edge.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state               <= ST_RUN;
      active              <= MENU;
      cand                <= MENU;
      fcnt                <= '0;
      {red, green, blue}  <= '0;
      game_rst            <= GAME_RST_RST;
      switching           <= 1'b0;
    end else begin
      state     <= nxt_state;
      active    <= nxt_active;
      cand      <= nxt_cand;
      fcnt      <= nxt_fcnt;
      switching <= (nxt_state != ST_RUN);
      if (nxt_state == ST_BLANK) begin
        {red, green, blue} <= '0;
        game_rst           <= '1;
      end else begin
        {red, green, blue} <= nxt_rgb;
        game_rst           <= ~(NUM_GAMES'(1) << nxt_active);
      end
    end
  end

endmodule

// File: tb/tb_game_channel_switch.sv
// Self-checking bench for game_channel_switch: select table, glitch, same-cycle change and reset corners.
// Latency: RGB checked one cycle after drive through a scoreboard queue.
// Backpressure: not applicable.
module tb_game_channel_switch;

  localparam int NG     = 6;
  localparam int SW     = 3;
  localparam int CW     = 4;
  localparam int RW     = 3 * CW;
  localparam int F      = 32;
  localparam int VS_LEN = 2;

  logic              clk_25MHz = 1'b0;
  logic              reset;
  logic [SW-1:0]     sel;
  logic              vsync;
  logic [NG*RW-1:0]  rgb_in;
  logic [CW-1:0]     red, green, blue;
  logic [NG-1:0]     game_rst;
  logic [SW-1:0]     active;
  logic              switching;

  game_channel_switch #(
    .NUM_GAMES(NG), .SEL_W(SW), .COLOR_W(CW), .SETTLE_FRAMES(2), .HOLD_FRAMES(1)
  ) dut (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .sel       (sel),
    .vsync     (vsync),
    .rgb_in    (rgb_in),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .game_rst  (game_rst),
    .active    (active),
    .switching (switching)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  typedef struct {
    logic [SW-1:0] sel;
    logic          exp_sw;
    logic [SW-1:0] exp_active;
    logic [NG-1:0] exp_rst;
  } vec_t;

  vec_t          vecs [8];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            phase    = 5;
  logic [RW-1:0] sb_q [$];
  logic          sb_en     = 1'b0;
  logic          sb_blank  = 1'b0;
  logic [SW-1:0] sb_active = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic [SW-1:0] a, input logic sw,
                             input logic [NG-1:0] gr);
    check({tag, ".active"}, 32'(active), 32'(a));
    check({tag, ".switching"}, 32'(switching), 32'(sw));
    check({tag, ".game_rst"}, 32'(game_rst), 32'(gr));
  endtask

  function automatic logic [RW-1:0] model_rgb(input logic [SW-1:0] g, input logic blank);
    logic [RW-1:0] r;
    r = rgb_in[int'(g)*RW +: RW];
    return blank ? '0 : r;
  endfunction

  // One clock: compare last cycle's expected colour, then drive this cycle's inputs.
  task automatic step();
    logic [RW-1:0] e;
    @(posedge clk_25MHz);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rgb", 32'({red, green, blue}), 32'(e));
    end
    phase = (phase + 1) % F;
    vsync = (phase >= VS_LEN);
    for (int g = 0; g < NG; g++) rgb_in[g*RW +: RW] = RW'($urandom);
    if (sb_en && !reset) sb_q.push_back(model_rgb(sb_active, sb_blank));
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < F && phase != p; i++) step();
  endtask

  // Advance until the edge that consumes the next frame_start cycle has happened.
  task automatic run_to_fs();
    for (int i = 0; i < F && phase != 0; i++) step();
    step();
  endtask

  task automatic sb_window(input logic [SW-1:0] a, input logic blank, input int n);
    sb_active = a;
    sb_blank  = blank;
    sb_en     = 1'b1;
    repeat (n) step();
    sb_en = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{sel: 3'd0, exp_sw: 1'b0, exp_active: 3'd0, exp_rst: 6'b111110};
    vecs[1] = '{sel: 3'd7, exp_sw: 1'b0, exp_active: 3'd0, exp_rst: 6'b111110};
    vecs[2] = '{sel: 3'd3, exp_sw: 1'b1, exp_active: 3'd3, exp_rst: 6'b110111};
    vecs[3] = '{sel: 3'd5, exp_sw: 1'b1, exp_active: 3'd5, exp_rst: 6'b011111};
    vecs[4] = '{sel: 3'd6, exp_sw: 1'b1, exp_active: 3'd0, exp_rst: 6'b111110};
    vecs[5] = '{sel: 3'd1, exp_sw: 1'b1, exp_active: 3'd1, exp_rst: 6'b111101};
    vecs[6] = '{sel: 3'd1, exp_sw: 1'b0, exp_active: 3'd1, exp_rst: 6'b111101};
    vecs[7] = '{sel: 3'd0, exp_sw: 1'b1, exp_active: 3'd0, exp_rst: 6'b111110};

    reset  = 1'b1;
    sel    = '0;
    vsync  = 1'b1;
    rgb_in = '0;
    step();
    step();
    check_state("reset", 3'd0, 1'b0, 6'b111110);
    check("reset.rgb", 32'({red, green, blue}), 32'd0);
    reset = 1'b0;

    // Idle on the menu for three frames; colour follows game 0 one cycle late.
    sb_window(3'd0, 1'b0, 3 * F);
    check_state("idle", 3'd0, 1'b0, 6'b111110);

    // Table of select values, each run through to a settled RUN state.
    for (int i = 0; i < 8; i++) begin
      wait_phase(4);
      sel = vecs[i].sel;
      step();
      step();
      check("vec.pre_settle", 32'(switching), 32'd0);
      step();
      check("vec.settle_entry", 32'(switching), 32'(vecs[i].exp_sw));
      if (vecs[i].exp_sw) begin
        run_to_fs();
        check("vec.still_settle", 32'(switching), 32'd1);
        run_to_fs();
        check_state("vec.blank", vecs[i].exp_active, 1'b1, 6'b111111);
        check("vec.blank_rgb", 32'({red, green, blue}), 32'd0);
        sb_window(vecs[i].exp_active, 1'b1, 4);
        run_to_fs();
      end
      check_state("vec.run", vecs[i].exp_active, 1'b0, vecs[i].exp_rst);
      sb_window(vecs[i].exp_active, 1'b0, 6);
    end

    // Select glitch 0->2->0 inside one frame: SETTLE is entered and left, screen never blanks.
    wait_phase(2);
    sb_active = 3'd0;
    sb_blank  = 1'b0;
    sb_en     = 1'b1;
    sel = 3'd2;
    step();
    step();
    step();
    check("glitch.settle", 32'(switching), 32'd1);
    sel = 3'd0;
    step();
    step();
    check("glitch.still_settle", 32'(switching), 32'd1);
    step();
    check_state("glitch.back", 3'd0, 1'b0, 6'b111110);
    run_to_fs();
    run_to_fs();
    check_state("glitch.after", 3'd0, 1'b0, 6'b111110);
    sb_en = 1'b0;
    step();

    // Candidate changes 1->4 on the very cycle of a frame_start: counter restarts.
    wait_phase(2);
    sel = 3'd1;
    step();
    step();
    step();
    check("race.settle", 32'(switching), 32'd1);
    run_to_fs();
    check_state("race.one_fs", 3'd0, 1'b1, 6'b111110);
    for (int i = 0; i < F && phase != F - 2; i++) step();
    sel = 3'd4;
    step();
    step();
    step();
    check_state("race.restart", 3'd0, 1'b1, 6'b111110);
    run_to_fs();
    check_state("race.one_more", 3'd0, 1'b1, 6'b111110);
    run_to_fs();
    check_state("race.blank", 3'd4, 1'b1, 6'b111111);
    run_to_fs();
    check_state("race.run", 3'd4, 1'b0, 6'b101111);
    sb_window(3'd4, 1'b0, 6);

    // Reset in the middle of BLANK clears everything without waiting for a clock edge.
    wait_phase(2);
    sel = 3'd2;
    step();
    step();
    step();
    run_to_fs();
    run_to_fs();
    check_state("rst.blank", 3'd2, 1'b1, 6'b111111);
    step();
    step();
    #5 reset = 1'b1;
    #2;
    check_state("rst.async", 3'd0, 1'b0, 6'b111110);
    check("rst.async_rgb", 32'({red, green, blue}), 32'd0);
    sel = 3'd0;
    step();
    step();
    reset = 1'b0;
    sb_window(3'd0, 1'b0, F + 8);
    check_state("rst.after", 3'd0, 1'b0, 6'b111110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
